// File: rtl/masked_rand_source_if.sv
// Seed-load / randomness-consumption bus of masked_rand_source.
// The master loads seeds and consumes words; the slave is the generator.
interface masked_rand_source_if;
    logic [92:0] seed;
    logic        seed_valid;
    logic        seed_ready;
    logic        en;
    logic [89:0] r_out;
    logic        r_valid;

    modport master (
        output seed,
        output seed_valid,
        output en,
        input  seed_ready,
        input  r_out,
        input  r_valid
    );

    modport slave (
        input  seed,
        input  seed_valid,
        input  en,
        output seed_ready,
        output r_out,
        output r_valid
    );
endinterface

// File: rtl/masked_rand_source.sv
// Fresh-randomness source for the 3-share masked S-box pair: three 31-bit LFSRs, 30 steps per advance.
// Optional macro RNG_FREERUN_EN: in READY the LFSRs and r_out advance every cycle regardless of en.
module masked_rand_source #(
    parameter int WARMUP = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    masked_rand_source_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_READY  = 2'd2
    } state_t;

    typedef struct packed {
        logic [30:0] state;
        logic [29:0] bits;
    } adv_t;

    localparam logic [7:0] LAST_CNT = 8'(WARMUP - 1);

    // 30 unrolled steps of x^31+x^28+1; output bit k is the feedback of step k.
    function automatic adv_t lfsr_advance(input logic [30:0] s_in);
        adv_t        res;
        logic [30:0] s;
        logic        fb;
        s        = s_in;
        res.bits = '0;
        for (int k = 0; k < 30; k++) begin
            fb          = s[30] ^ s[27];
            res.bits[k] = fb;
            s           = {s[29:0], fb};
        end
        res.state = s;
        return res;
    endfunction

    // An all-zero slice would lock its LFSR, so it is replaced by 1.
    function automatic logic [30:0] zero_guard(input logic [30:0] v);
        return (v == '0) ? 31'h1 : v;
    endfunction

    state_t      state, state_nxt;
    logic [30:0] lfsr_a, lfsr_b, lfsr_c;
    logic [7:0]  cnt;
    logic [89:0] r_q;

    adv_t adv_a, adv_b, adv_c;
    logic handshake;
    logic consume;
    logic load, advance, capture, cnt_inc;

    assign adv_a = lfsr_advance(lfsr_a);
    assign adv_b = lfsr_advance(lfsr_b);
    assign adv_c = lfsr_advance(lfsr_c);

    // Handshake flags are pure decodes of the state register.
    assign bus.seed_ready = (state == ST_IDLE) || (state == ST_READY);
    assign bus.r_valid    = (state == ST_READY);
    assign bus.r_out      = r_q;

    assign handshake = bus.seed_valid && bus.seed_ready;

`ifdef RNG_FREERUN_EN
    assign consume = 1'b1;
`else
    assign consume = bus.en;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        advance   = 1'b0;
        capture   = 1'b0;
        cnt_inc   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (handshake) begin
                    load      = 1'b1;
                    state_nxt = ST_WARMUP;
                end
            end
            ST_WARMUP: begin
                advance = 1'b1;
                cnt_inc = 1'b1;
                if (cnt == LAST_CNT) begin
                    capture   = 1'b1;
                    state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                // A reseed takes priority over consumption in the same cycle.
                if (handshake) begin
                    load      = 1'b1;
                    state_nxt = ST_WARMUP;
                end else if (consume) begin
                    advance = 1'b1;
                    capture = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_a <= '0;
            lfsr_b <= '0;
            lfsr_c <= '0;
            cnt    <= '0;
            r_q    <= '0;
        end else begin
            if (load) begin
                lfsr_a <= zero_guard(bus.seed[30:0]);
                lfsr_b <= zero_guard(bus.seed[61:31]);
                lfsr_c <= zero_guard(bus.seed[92:62]);
                cnt    <= '0;
            end else begin
                if (advance) begin
                    lfsr_a <= adv_a.state;
                    lfsr_b <= adv_b.state;
                    lfsr_c <= adv_c.state;
                end
                if (cnt_inc) begin
                    cnt <= cnt + 8'd1;
                end
            end
            if (capture) begin
                r_q <= {adv_c.bits, adv_b.bits, adv_a.bits};
            end
        end
    end

endmodule
